// File: rtl/dfr_matrix_multiply_if.sv
// Memory/handshake bundle for dfr_matrix_multiply.
// slave  : the multiplier (drives addresses, Z write port and busy).
// master : the controller/RAM side (drives start and the X/Y read data).
interface dfr_matrix_multiply_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                  start;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] x_addr;
  logic [DATA_WIDTH-1:0] x_data;
  logic [ADDR_WIDTH-1:0] y_addr;
  logic [DATA_WIDTH-1:0] y_data;
  logic [ADDR_WIDTH-1:0] z_addr;
  logic [DATA_WIDTH-1:0] z_data;
  logic                  z_wen;

  modport slave (
    input  start, x_data, y_data,
    output busy, x_addr, y_addr, z_addr, z_data, z_wen
  );

  modport master (
    output start, x_data, y_data,
    input  busy, x_addr, y_addr, z_addr, z_data, z_wen
  );
endinterface

// File: rtl/dfr_matrix_multiply.sv
// Sequential fixed-point matrix multiplier Z = X * Y for the DFR output layer.
// One multiply-accumulate per FETCH/ACCUM pair against 1-cycle-latency RAMs.
// Build option: define DFR_MATRIX_MULTIPLY_SATURATE_EN to clamp results to the
// signed DATA_WIDTH range; otherwise results wrap to the low DATA_WIDTH bits.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start, busy low
// S_FETCH | x_addr/y_addr presented for (i,k),(k,j)
// S_ACCUM | RAM data valid, acc += x*y, step k or go write
// S_WRITE | z_wen high for Z[i][j], step j/i or finish
module dfr_matrix_multiply #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int X_ROWS        = 5,
  parameter int Y_COLS        = 5,
  parameter int X_COLS_Y_ROWS = 5,
  parameter int FRAC_BITS     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  dfr_matrix_multiply_if.slave  mm
);

  // Guard bits cover K full-scale products plus sign, so acc cannot overflow.
  localparam int ACC_W = 2*DATA_WIDTH + $clog2(X_COLS_Y_ROWS) + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ACCUM, S_WRITE} state_t;

  state_t                  state_q, state_d;
  logic                    busy_q, busy_d;
  logic [31:0]             i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ADDR_WIDTH-1:0]   x_addr_q, x_addr_d;
  logic [ADDR_WIDTH-1:0]   y_addr_q, y_addr_d;
  logic [ADDR_WIDTH-1:0]   z_addr_q, z_addr_d;
  logic [ADDR_WIDTH-1:0]   z_cnt_q, z_cnt_d;
  logic [DATA_WIDTH-1:0]   z_data_q, z_data_d;
  logic                    z_wen_q, z_wen_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]        acc_sum;
  logic signed [ACC_W-1:0]        acc_sh;
  logic [DATA_WIDTH-1:0]          z_scaled;

  assign prod    = $signed(mm.x_data) * $signed(mm.y_data);
  assign acc_sum = acc_q + $signed({{(ACC_W-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod});
  assign acc_sh  = acc_sum >>> FRAC_BITS;

`ifdef DFR_MATRIX_MULTIPLY_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Clamp the scaled sum into the signed result range.
  always_comb begin
    z_scaled = DATA_WIDTH'(acc_sh);
    if (acc_sh > SAT_MAX)      z_scaled = SAT_MAX[DATA_WIDTH-1:0];
    else if (acc_sh < SAT_MIN) z_scaled = SAT_MIN[DATA_WIDTH-1:0];
  end
`else
  assign z_scaled = DATA_WIDTH'(acc_sh);
`endif

  // Next-state and datapath: addresses are stepped incrementally so no
  // run-time multipliers are needed for i*K+k, k*C+j or i*C+j.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    x_addr_d = x_addr_q;
    y_addr_d = y_addr_q;
    z_addr_d = z_addr_q;
    z_cnt_d  = z_cnt_q;
    z_data_d = z_data_q;
    z_wen_d  = 1'b0;
    acc_d    = acc_q;

    case (state_q)
      S_IDLE: begin
        if (mm.start) begin
          state_d  = S_FETCH;
          busy_d   = 1'b1;
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
          acc_d    = '0;
          x_addr_d = '0;
          y_addr_d = '0;
          z_cnt_d  = '0;
        end
      end
      S_FETCH: begin
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        acc_d = acc_sum;
        if (k_q == X_COLS_Y_ROWS-1) begin
          // Z word is registered here so it is stable for the whole WRITE cycle.
          state_d  = S_WRITE;
          z_wen_d  = 1'b1;
          z_data_d = z_scaled;
          z_addr_d = z_cnt_q;
        end else begin
          state_d  = S_FETCH;
          k_d      = k_q + 32'd1;
          x_addr_d = x_addr_q + ADDR_WIDTH'(1);
          y_addr_d = y_addr_q + ADDR_WIDTH'(Y_COLS);
        end
      end
      S_WRITE: begin
        acc_d   = '0;
        k_d     = '0;
        z_cnt_d = z_cnt_q + ADDR_WIDTH'(1);
        if (j_q < Y_COLS-1) begin
          state_d  = S_FETCH;
          j_d      = j_q + 32'd1;
          x_addr_d = x_addr_q - ADDR_WIDTH'(X_COLS_Y_ROWS-1);
          y_addr_d = ADDR_WIDTH'(j_q + 32'd1);
        end else if (i_q < X_ROWS-1) begin
          state_d  = S_FETCH;
          j_d      = '0;
          i_d      = i_q + 32'd1;
          x_addr_d = x_addr_q + ADDR_WIDTH'(1);
          y_addr_d = '0;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      x_addr_q <= '0;
      y_addr_q <= '0;
      z_addr_q <= '0;
      z_cnt_q  <= '0;
      z_data_q <= '0;
      z_wen_q  <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      x_addr_q <= x_addr_d;
      y_addr_q <= y_addr_d;
      z_addr_q <= z_addr_d;
      z_cnt_q  <= z_cnt_d;
      z_data_q <= z_data_d;
      z_wen_q  <= z_wen_d;
      acc_q    <= acc_d;
    end
  end

  assign mm.busy   = busy_q;
  assign mm.x_addr = x_addr_q;
  assign mm.y_addr = y_addr_q;
  assign mm.z_addr = z_addr_q;
  assign mm.z_data = z_data_q;
  assign mm.z_wen  = z_wen_q;

endmodule

// File: tb/tb_dfr_matrix_multiply.sv
// Directed bench for dfr_matrix_multiply: dut0 uses FRAC_BITS=0, dut1 FRAC_BITS=4.
module tb_dfr_matrix_multiply;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  dfr_matrix_multiply_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0 ();
  dfr_matrix_multiply_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1 ();

  dfr_matrix_multiply #(.FRAC_BITS(0)) dut0 (.clk(clk), .rst(rst), .mm(m0.slave));
  dfr_matrix_multiply #(.FRAC_BITS(4)) dut1 (.clk(clk), .rst(rst), .mm(m1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] xmem [25];
  logic [31:0] ymem [25];
  logic [31:0] zmem0 [25];
  logic [31:0] zmem1 [25];
  int          wlog0 [64];
  int          wcnt0, wcnt1, busy0, busy1;

  // 1-cycle-latency read RAMs shared by both instances.
  always @(posedge clk) begin
    m0.x_data <= (m0.x_addr < 25) ? xmem[m0.x_addr] : 32'h0;
    m0.y_data <= (m0.y_addr < 25) ? ymem[m0.y_addr] : 32'h0;
    m1.x_data <= (m1.x_addr < 25) ? xmem[m1.x_addr] : 32'h0;
    m1.y_data <= (m1.y_addr < 25) ? ymem[m1.y_addr] : 32'h0;
  end

  // Z write capture and busy-cycle counting, sampled mid-cycle.
  always @(negedge clk) begin
    if (m0.z_wen) begin
      if (m0.z_addr < 25) zmem0[m0.z_addr] = m0.z_data;
      if (wcnt0 < 64) wlog0[wcnt0] = int'(m0.z_addr);
      wcnt0++;
    end
    if (m1.z_wen) begin
      if (m1.z_addr < 25) zmem1[m1.z_addr] = m1.z_data;
      wcnt1++;
    end
    if (m0.busy) busy0++;
    if (m1.busy) busy1++;
  end

  task automatic fill(input int mode);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        case (mode)
          0: begin xmem[r*5+c] = (r == c) ? 32'd1 : 32'd0; ymem[r*5+c] = 32'(5*r + c + 1); end
          1: begin xmem[r*5+c] = 32'd2; ymem[r*5+c] = -32'sd3; end
          2: begin xmem[r*5+c] = 32'h7FFFFFFF; ymem[r*5+c] = 32'h7FFFFFFF; end
          default: begin xmem[r*5+c] = 32'd16; ymem[r*5+c] = 32'd16; end
        endcase
      end
    for (int a = 0; a < 25; a++) begin
      zmem0[a] = 32'hDEADBEEF;
      zmem1[a] = 32'hDEADBEEF;
    end
    for (int a = 0; a < 64; a++) wlog0[a] = -1;
    wcnt0 = 0; wcnt1 = 0; busy0 = 0; busy1 = 0;
  endtask

  // Pulses start on the selected DUT, optionally re-pulses it at run cycles
  // ra/rb, and waits (bounded) for busy to drop.
  task automatic run(input bit sel, input int ra, input int rb,
                     output bit busy_after_start, output bit timed_out);
    int n;
    @(negedge clk);
    if (sel) m1.start = 1'b1; else m0.start = 1'b1;
    @(negedge clk);
    m0.start = 1'b0; m1.start = 1'b0;
    busy_after_start = sel ? m1.busy : m0.busy;
    n = 1;
    timed_out = 1'b0;
    while ((sel ? m1.busy : m0.busy) && n < 2000) begin
      if (n == ra || n == rb) begin
        if (sel) m1.start = 1'b1; else m0.start = 1'b1;
      end
      @(negedge clk);
      m0.start = 1'b0; m1.start = 1'b0;
      n++;
    end
    if (n >= 2000) timed_out = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; m0.start = 1'b0; m1.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m0.busy !== 1'b0 || m0.z_wen !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: busy=%b z_wen=%b, required 0 0", m0.busy, m0.z_wen);
    end
    n_checks++;
    if (m0.x_addr !== 32'd0 || m0.y_addr !== 32'd0 || m0.z_addr !== 32'd0 || m0.z_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_bus: x=%h y=%h z=%h d=%h, required all 0",
                         m0.x_addr, m0.y_addr, m0.z_addr, m0.z_data);
    end
    n_checks++;
    if (m1.busy !== 1'b0 || m1.z_wen !== 1'b0) begin
      n_fail++; $display("FAIL reset_dut1: busy=%b z_wen=%b, required 0 0", m1.busy, m1.z_wen);
    end
  endtask

  task automatic check_identity_run(input string tag);
    int bad_val, bad_ord;
    bad_val = 0; bad_ord = 0;
    n_checks++;
    if (wcnt0 !== 25) begin n_fail++; $display("FAIL %s_writes: got %0d, required 25", tag, wcnt0); end
    n_checks++;
    if (busy0 !== 275) begin n_fail++; $display("FAIL %s_busy_len: got %0d, required 275", tag, busy0); end
    for (int a = 0; a < 25; a++) begin
      if (zmem0[a] !== 32'(a + 1)) bad_val++;
      if (wlog0[a] !== a) bad_ord++;
    end
    n_checks++;
    if (bad_val != 0) begin n_fail++; $display("FAIL %s_values: %0d wrong words, Z[0]=%0d Z[24]=%0d, required 1 and 25", tag, bad_val, zmem0[0], zmem0[24]); end
    n_checks++;
    if (bad_ord != 0) begin n_fail++; $display("FAIL %s_order: %0d out of order, first=%0d last=%0d, required 0..24", tag, bad_ord, wlog0[0], wlog0[24]); end
  endtask

  task automatic test_identity;
    bit b, t;
    fill(0);
    run(1'b0, -1, -1, b, t);
    n_checks++;
    if (b !== 1'b1) begin n_fail++; $display("FAIL identity_busy_rise: busy=%b, required 1", b); end
    n_checks++;
    if (t) begin n_fail++; $display("FAIL identity_timeout: busy stuck=1, required 0"); end
    check_identity_run("identity");
    n_checks++;
    if (m0.z_wen !== 1'b0) begin n_fail++; $display("FAIL identity_idle_wen: z_wen=%b, required 0", m0.z_wen); end
  endtask

  task automatic test_const_neg;
    bit b, t;
    int bad;
    fill(1);
    run(1'b0, -1, -1, b, t);
    bad = 0;
    for (int a = 0; a < 25; a++) if (zmem0[a] !== 32'hFFFFFFE2) bad++;
    n_checks++;
    if (t || wcnt0 !== 25 || bad != 0) begin
      n_fail++; $display("FAIL const_neg: writes=%0d bad=%0d Z[0]=%h, required 25 0 ffffffe2", wcnt0, bad, zmem0[0]);
    end
  endtask

  task automatic test_overflow;
    bit b, t;
    int bad;
    logic [31:0] exp_z;
`ifdef DFR_MATRIX_MULTIPLY_SATURATE_EN
    exp_z = 32'h7FFFFFFF;
`else
    exp_z = 32'h00000005;
`endif
    fill(2);
    run(1'b0, -1, -1, b, t);
    bad = 0;
    for (int a = 0; a < 25; a++) if (zmem0[a] !== exp_z) bad++;
    n_checks++;
    if (t || wcnt0 !== 25 || bad != 0) begin
      n_fail++; $display("FAIL overflow: writes=%0d bad=%0d Z[0]=%h, required 25 0 %h", wcnt0, bad, zmem0[0], exp_z);
    end
  endtask

  task automatic test_mid_reset;
    bit b, t;
    int snap;
    fill(0);
    @(negedge clk); m0.start = 1'b1;
    @(negedge clk); m0.start = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (m0.busy !== 1'b0 || m0.z_wen !== 1'b0) begin
      n_fail++; $display("FAIL midrst_next: busy=%b z_wen=%b, required 0 0", m0.busy, m0.z_wen);
    end
    snap = wcnt0;
    repeat (300) @(negedge clk);
    #1;
    n_checks++;
    if (wcnt0 !== snap || m0.busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_quiet: writes after rst=%0d busy=%b, required 0 0", wcnt0 - snap, m0.busy);
    end
    fill(0);
    run(1'b0, -1, -1, b, t);
    check_identity_run("midrst_rerun");
  endtask

  task automatic test_restart_ignored;
    bit b, t;
    fill(0);
    run(1'b0, 10, 200, b, t);
    check_identity_run("restart");
  endtask

  task automatic test_rst_start_collision;
    fill(0);
    @(negedge clk);
    rst = 1'b1; m0.start = 1'b1;
    @(negedge clk);
    rst = 1'b0; m0.start = 1'b0;
    n_checks++;
    if (m0.busy !== 1'b0) begin n_fail++; $display("FAIL collision_busy: busy=%b, required 0", m0.busy); end
    repeat (20) @(negedge clk);
    #1;
    n_checks++;
    if (m0.busy !== 1'b0 || wcnt0 !== 0) begin
      n_fail++; $display("FAIL collision_idle: busy=%b writes=%0d, required 0 0", m0.busy, wcnt0);
    end
  endtask

  task automatic test_frac;
    bit b, t;
    int bad;
    fill(3);
    run(1'b1, -1, -1, b, t);
    bad = 0;
    for (int a = 0; a < 25; a++) if (zmem1[a] !== 32'd80) bad++;
    n_checks++;
    if (t || wcnt1 !== 25 || bad != 0) begin
      n_fail++; $display("FAIL frac: writes=%0d bad=%0d Z[0]=%0d, required 25 0 80", wcnt1, bad, zmem1[0]);
    end
    n_checks++;
    if (busy1 !== 275 || wcnt0 !== 0) begin
      n_fail++; $display("FAIL frac_timing: busy=%0d dut0 writes=%0d, required 275 0", busy1, wcnt0);
    end
  endtask

  initial begin
    rst = 1'b1;
    m0.start = 1'b0; m1.start = 1'b0;
    wcnt0 = 0; wcnt1 = 0; busy0 = 0; busy1 = 0;
    test_reset;
    test_identity;
    test_const_neg;
    test_overflow;
    test_mid_reset;
    test_restart_ignored;
    test_rst_start_collision;
    test_frac;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
